// File: rtl/dizy_keystream_ctrl_pkg.sv
// rtl/dizy_keystream_ctrl_pkg.sv - shared types and defaults for the DIZY keystream controller
package dizy_keystream_ctrl_pkg;

  localparam int SIZE_STATE_DEF   = 128;
  localparam int SIZE_KEY_DEF     = 128;
  localparam int KS_WIDTH_DEF     = 32;
  localparam int WARMUP_STEPS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_IV,
    ST_WARMUP,
    ST_RUN
  } ks_state_e;

  function automatic logic is_init_state(ks_state_e s);
    return (s == ST_LOAD_KEY) || (s == ST_LOAD_IV) || (s == ST_WARMUP);
  endfunction

endpackage

// File: rtl/dizy_keystream_ctrl_if.sv
// rtl/dizy_keystream_ctrl_if.sv - data-in / data-out valid-ready stream bundle
interface dizy_keystream_ctrl_if import dizy_keystream_ctrl_pkg::*; #(
  parameter int KS_WIDTH = KS_WIDTH_DEF
);
  logic                din_valid;
  logic                din_ready;
  logic [KS_WIDTH-1:0] din_data;
  logic                dout_valid;
  logic                dout_ready;
  logic [KS_WIDTH-1:0] dout_data;

  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data
  );

  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/dizy_ks_out_reg.sv
// rtl/dizy_ks_out_reg.sv - one-entry output register that XORs keystream into the data word
module dizy_ks_out_reg import dizy_keystream_ctrl_pkg::*; #(
  parameter int KS_WIDTH = KS_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                ks_avail,
  input  logic [KS_WIDTH-1:0] ks,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [KS_WIDTH-1:0] din_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [KS_WIDTH-1:0] dout_data,
  output logic                xfer
);
  logic                dout_valid_q, dout_valid_d;
  logic [KS_WIDTH-1:0] dout_data_q, dout_data_d;

  assign din_ready  = ks_avail & (~dout_valid_q | dout_ready);
  assign xfer       = din_valid & din_ready;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;

  always_comb begin
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    if (flush) begin
      // A restart discards whatever word is still waiting downstream.
      dout_valid_d = 1'b0;
      dout_data_d  = '0;
    end else if (xfer) begin
      dout_valid_d = 1'b1;
      dout_data_d  = din_data ^ ks;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end
endmodule

// File: rtl/dizy_keystream_ctrl.sv
// rtl/dizy_keystream_ctrl.sv - DIZY core sequencer (key/IV load, warm-up) and keystream XOR stage
module dizy_keystream_ctrl import dizy_keystream_ctrl_pkg::*; #(
  parameter int SIZE_STATE   = SIZE_STATE_DEF,
  parameter int SIZE_KEY     = SIZE_KEY_DEF,
  parameter int KS_WIDTH     = KS_WIDTH_DEF,
  parameter int KS_OFFSET    = 0,
  parameter int WARMUP_STEPS = WARMUP_STEPS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SIZE_KEY-1:0]   key,
  input  logic [SIZE_KEY-1:0]   iv,
  output logic                  busy,
  dizy_keystream_ctrl_if.slave  dio,
  output logic                  core_load,
  output logic                  core_next,
  output logic [SIZE_KEY-1:0]   core_key,
  input  logic                  core_busy,
  input  logic [SIZE_STATE-1:0] core_state
);
  localparam int CW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
  localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);

  ks_state_e     state_q, state_d;
  logic [SIZE_KEY-1:0] key_q, key_d, iv_q, iv_d;
  logic [CW-1:0] warm_cnt_q, warm_cnt_d;
  logic          step_ok;
  logic          run_xfer;
  logic [KS_WIDTH-1:0] ks;
  logic          unused_state;

  assign ks           = core_state[KS_OFFSET +: KS_WIDTH];
  assign unused_state = ^core_state;

  // Core pulses are suppressed on reset and restart so a dying sequence never touches the core.
  assign step_ok   = ~rst & ~start & ~core_busy;
  assign busy      = is_init_state(state_q);
  assign core_load = step_ok & (state_q == ST_LOAD_KEY);
  assign core_next = (step_ok & ((state_q == ST_LOAD_IV) | (state_q == ST_WARMUP))) | run_xfer;
  assign core_key  = core_load ? key_q :
                     (step_ok && state_q == ST_LOAD_IV) ? iv_q : '0;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    iv_d       = iv_q;
    warm_cnt_d = warm_cnt_q;
    if (start) begin
      key_d      = key;
      iv_d       = iv;
      warm_cnt_d = '0;
      state_d    = ST_LOAD_KEY;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD_KEY: if (!core_busy) state_d = ST_LOAD_IV;
        ST_LOAD_IV: if (!core_busy) begin
          warm_cnt_d = '0;
          state_d    = (WARMUP_STEPS == 0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: if (!core_busy) begin
          if (warm_cnt_q == WARM_LAST) state_d = ST_RUN;
          else warm_cnt_d = warm_cnt_q + 1'b1;
        end
        ST_RUN: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      iv_q       <= '0;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  dizy_ks_out_reg #(.KS_WIDTH(KS_WIDTH)) u_out (
    .clk        (clk),
    .rst        (rst),
    .flush      (start),
    .ks_avail   ((state_q == ST_RUN) & step_ok),
    .ks         (ks),
    .din_valid  (dio.din_valid),
    .din_ready  (dio.din_ready),
    .din_data   (dio.din_data),
    .dout_valid (dio.dout_valid),
    .dout_ready (dio.dout_ready),
    .dout_data  (dio.dout_data),
    .xfer       (run_xfer)
  );
endmodule

// File: tb/tb_dizy_keystream_ctrl.sv
// tb/tb_dizy_keystream_ctrl.sv - self-checking bench with stub core and keystream scoreboard
module tb_dizy_keystream_ctrl;
  localparam int SW = 128;
  localparam int KW = 128;
  localparam int W  = 32;
  localparam int WS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT 1: WARMUP_STEPS = 4
  logic          start;
  logic [KW-1:0] key, iv;
  logic          busy, core_load, core_next;
  logic          core_busy;
  logic [KW-1:0] core_key;
  logic [SW-1:0] core_state;
  dizy_keystream_ctrl_if #(.KS_WIDTH(W)) dio();

  dizy_keystream_ctrl #(.SIZE_STATE(SW), .SIZE_KEY(KW), .KS_WIDTH(W), .KS_OFFSET(0),
                        .WARMUP_STEPS(WS)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .busy(busy),
    .dio(dio.slave), .core_load(core_load), .core_next(core_next), .core_key(core_key),
    .core_busy(core_busy), .core_state(core_state));

  // DUT 2: WARMUP_STEPS = 0
  logic          start2;
  logic [KW-1:0] key2, iv2;
  logic          busy2, core_load2, core_next2;
  logic [KW-1:0] core_key2;
  logic [SW-1:0] core_state2;
  dizy_keystream_ctrl_if #(.KS_WIDTH(W)) dio2();

  dizy_keystream_ctrl #(.SIZE_STATE(SW), .SIZE_KEY(KW), .KS_WIDTH(W), .KS_OFFSET(0),
                        .WARMUP_STEPS(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .key(key2), .iv(iv2), .busy(busy2),
    .dio(dio2.slave), .core_load(core_load2), .core_next(core_next2), .core_key(core_key2),
    .core_busy(core_busy), .core_state(core_state2));

  // Stub cores
  always_ff @(posedge clk) begin
    if (core_load) core_state <= core_key;
    else if (core_next) core_state <= core_state + core_key + 128'd1;
    if (core_load2) core_state2 <= core_key2;
    else if (core_next2) core_state2 <= core_state2 + core_key2 + 128'd1;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: after start, 2+WS init cycles, then keystream = key+iv+1+WS, +1 per word used.
  bit            started = 1'b0;
  int            busy_left = 0;
  logic [127:0]  model_ks = '0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  out_log[$];
  int            out_cyc[$];
  int            cyc = 0;
  int            cnt_load = 0;
  int            cnt_next = 0;

  always @(negedge clk) begin
    logic exp_valid, exp_ready, run_now;
    cyc++;
    if (core_load) cnt_load++;
    if (core_next) cnt_next++;
    run_now   = started && (busy_left == 0);
    exp_valid = (exp_q.size() != 0);
    exp_ready = !rst && !start && run_now && (!exp_valid || dio.dout_ready);
    check("busy", 128'(busy), 128'(started && busy_left > 0));
    check("dout_valid", 128'(dio.dout_valid), 128'(exp_valid));
    if (exp_valid) check("dout_data", 128'(dio.dout_data), 128'(exp_q[0]));
    check("din_ready", 128'(dio.din_ready), 128'(exp_ready));
    check("load_next_exclusive", 128'(core_load & core_next), 128'(0));
    if (rst) begin
      started   = 1'b0;
      busy_left = 0;
      exp_q.delete();
    end else if (start) begin
      started   = 1'b1;
      busy_left = 2 + WS;
      model_ks  = key + iv + 128'(1 + WS);
      exp_q.delete();
    end else begin
      if (exp_valid && dio.dout_ready) begin
        void'(exp_q.pop_front());
        out_log.push_back(dio.dout_data);
        out_cyc.push_back(cyc);
      end
      if (dio.din_valid && exp_ready) begin
        exp_q.push_back(dio.din_data ^ model_ks[W-1:0]);
        model_ks = model_ks + 128'd1;
      end
      if (busy_left > 0) busy_left--;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dio.din_ready) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    check(nm, 128'(ok), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc, l0, n0, base;
    start = 0; key = '0; iv = '0;
    start2 = 0; key2 = '0; iv2 = '0;
    core_busy = 1'b0;
    dio.din_valid = 0; dio.din_data = '0; dio.dout_ready = 0;
    dio2.din_valid = 0; dio2.din_data = '0; dio2.dout_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_din_ready", 128'(dio.din_ready), 128'(0));
    check("rst_dout_valid", 128'(dio.dout_valid), 128'(0));
    check("rst_dout_data", 128'(dio.dout_data), 128'(0));
    check("rst_core_load", 128'(core_load), 128'(0));
    check("rst_core_next", 128'(core_next), 128'(0));
    check("rst_core_key", core_key, 128'(0));
    check("rst_busy2", 128'(busy2), 128'(0));
    tick;
    rst = 0;
    tick;

    // Scenario 1: init sequence
    l0 = cnt_load; n0 = cnt_next;
    start = 1; key = 128'h10; iv = 128'h5;
    tick;
    start = 0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      @(posedge clk);
      #1;
    end
    check("s1_busy_cycles", 128'(bc), 128'(6));
    check("s1_load_pulses", 128'(cnt_load - l0), 128'(1));
    check("s1_next_pulses", 128'(cnt_next - n0), 128'(5));
    check("s1_core_state", core_state, 128'h1A);
    check("s1_run_ready", 128'(dio.din_ready), 128'(1));
    tick;

    // Scenario 2: back-to-back stream
    base = out_log.size();
    dio.din_valid = 1; dio.din_data = '0; dio.dout_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s2_din_ready", 128'(dio.din_ready), 128'(1));
      tick;
    end
    dio.din_valid = 0;
    repeat (3) tick;
    check("s2_count", 128'(out_log.size() - base), 128'(3));
    if (out_log.size() >= base + 3) begin
      check("s2_word0", 128'(out_log[base]), 128'h1A);
      check("s2_word1", 128'(out_log[base+1]), 128'h1B);
      check("s2_word2", 128'(out_log[base+2]), 128'h1C);
      check("s2_consecutive", 128'(out_cyc[base+2] - out_cyc[base]), 128'(2));
    end

    // Scenario 3: backpressure after the first word
    dio.dout_ready = 0; dio.din_valid = 1; dio.din_data = '0;
    start = 1;
    tick;
    start = 0;
    wait_run("s3_reach_run");
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_hold_valid", 128'(dio.dout_valid), 128'(1));
      check("s3_hold_data", 128'(dio.dout_data), 128'h1A);
      check("s3_hold_din_ready", 128'(dio.din_ready), 128'(0));
      tick;
    end
    dio.dout_ready = 1;
    @(negedge clk);
    check("s3_release_ready", 128'(dio.din_ready), 128'(1));
    tick;
    dio.din_valid = 0;
    @(negedge clk);
    check("s3_next_word", 128'(dio.dout_data), 128'h1B);
    tick;

    // Scenario 5: restart with a pending output word
    dio.dout_ready = 0; dio.din_valid = 1; dio.din_data = '0;
    @(negedge clk);
    check("s5_accept", 128'(dio.din_ready), 128'(1));
    tick;
    dio.din_valid = 0;
    @(negedge clk);
    check("s5_pending", 128'(dio.dout_valid), 128'(1));
    check("s5_pending_data", 128'(dio.dout_data), 128'h1C);
    tick;
    start = 1;
    tick;
    start = 0;
    @(negedge clk);
    check("s5_dropped", 128'(dio.dout_valid), 128'(0));
    tick;
    dio.din_valid = 1; dio.din_data = 32'hFFFF0000; dio.dout_ready = 1;
    wait_run("s5_reach_run");
    tick;
    dio.din_valid = 0;
    @(negedge clk);
    check("s5_first_ks", 128'(dio.dout_data), 128'hFFFF001A);
    tick;

    // Scenario 6: reset during warm-up
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    rst = 1;
    @(negedge clk);
    check("s6_no_pulse_in_rst", 128'(core_next | core_load), 128'(0));
    tick;
    rst = 0;
    l0 = cnt_load; n0 = cnt_next;
    @(negedge clk);
    check("s6_busy", 128'(busy), 128'(0));
    check("s6_din_ready", 128'(dio.din_ready), 128'(0));
    check("s6_dout_valid", 128'(dio.dout_valid), 128'(0));
    check("s6_dout_data", 128'(dio.dout_data), 128'(0));
    check("s6_core_key", core_key, 128'(0));
    repeat (5) tick;
    check("s6_no_more_pulses", 128'((cnt_load - l0) + (cnt_next - n0)), 128'(0));

    // Scenario 4: WARMUP_STEPS = 0 instance
    start2 = 1; key2 = 128'h10; iv2 = 128'h5;
    tick;
    start2 = 0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy2) break;
      bc++;
      @(posedge clk);
      #1;
    end
    check("s4_busy_cycles", 128'(bc), 128'(2));
    tick;
    dio2.din_valid = 1; dio2.din_data = '0; dio2.dout_ready = 1;
    @(negedge clk);
    check("s4_din_ready", 128'(dio2.din_ready), 128'(1));
    tick;
    dio2.din_valid = 0;
    @(negedge clk);
    check("s4_dout_valid", 128'(dio2.dout_valid), 128'(1));
    check("s4_first_ks", 128'(dio2.dout_data), 128'h16);
    tick;

    // Randomized phase against the model
    base = out_log.size();
    start = 1; key = {$urandom, $urandom, $urandom, $urandom}; iv = {$urandom, $urandom, $urandom, $urandom};
    tick;
    start = 0;
    for (int i = 0; i < 3000; i++) begin
      dio.din_valid  = ($urandom_range(0, 3) != 0);
      dio.din_data   = $urandom;
      dio.dout_ready = ($urandom_range(0, 2) != 0);
      start = ($urandom_range(0, 199) == 0);
      rst   = !start && ($urandom_range(0, 599) == 0);
      if (start) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        iv  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (rst || (!started && !start && $urandom_range(0, 9) == 0)) begin
        tick;
        rst = 0;
        start = 1;
        key = {$urandom, $urandom, $urandom, $urandom};
      end
      tick;
    end
    start = 0; rst = 0; dio.din_valid = 0; dio.dout_ready = 1;
    repeat (4) tick;
    check("rand_activity", 128'(out_log.size() - base > 500), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
